// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath package (divider and shift-add multiplier).
// Holds the FSM state encoding, the default operand width and the
// iteration-counter width helper.
package arith_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Counter must hold values 0..w, so size it for w+1 states.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_sub_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   rem_i     : partial remainder before this step (W+1 bits)
//   bit_i     : next dividend bit, shifted into the remainder LSB
//   divisor_i : divisor (W bits)
//   rem_o     : partial remainder after shift and conditional subtract
//   q_o       : quotient bit produced by this step
module shift_sub_step #(
  parameter int W = 16
) (
  input  logic [W:0]   rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);

  logic [W:0] sh;
  logic [W:0] diff;

  assign sh   = {rem_i[W-1:0], bit_i};
  assign diff = sh - {1'b0, divisor_i};
  // With the usual R < divisor invariant rem_i[W] is 0; if it were set the
  // true shifted value would exceed any W-bit divisor, so subtract anyway.
  assign q_o   = rem_i[W] | (sh >= {1'b0, divisor_i});
  assign rem_o = q_o ? diff : sh;

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring (shift-subtract) divider with start/done handshake.
// Build option: define SHIFT_SUB_DIVIDER_SIGNED_EN for two's-complement
// operands (magnitudes through the unsigned core, sign fix-up in FINISH).
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   dividend, divisor   : operands, sampled on an accepted start
//   start               : request pulse, honoured only in IDLE
//   quotient, remainder : registered results, updated in FINISH only
//   busy                : high while iterating (CALC)
//   done                : one-cycle pulse when results become valid
//   div_by_zero         : set with done for a zero divisor, cleared on start
// TOP_WIDTH must be 2 or more.
module shift_sub_divider
  import arith_pkg::*;
#(
  parameter int TOP_WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TOP_WIDTH-1:0] dividend,
  input  logic [TOP_WIDTH-1:0] divisor,
  input  logic                 start,
  output logic [TOP_WIDTH-1:0] quotient,
  output logic [TOP_WIDTH-1:0] remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero
);

  localparam int W  = TOP_WIDTH;
  localparam int CW = cnt_w(W);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W:0]     prem_q, prem_d, step_rem;
  // dsr: dividend shift register; quotient bits enter at the LSB as the
  // dividend bits leave at the MSB, so after W steps it holds the quotient.
  logic [W-1:0]   dsr_q, dsr_d, dvs_q, dvs_d;
  logic [W-1:0]   quot_q, quot_d, rem_q, rem_d;
  logic           done_q, done_d, dz_q, dz_d, step_q;
  logic [W-1:0]   dvd_mag, dvs_mag, q_fix, r_fix, dz_quot, dz_rem;

  shift_sub_step #(.W(W)) u_step (
    .rem_i     (prem_q),
    .bit_i     (dsr_q[W-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
  logic dneg_q, dneg_d, qneg_q, qneg_d;

  assign dvd_mag = dividend[W-1] ? W'(0) - dividend : dividend;
  assign dvs_mag = divisor[W-1]  ? W'(0) - divisor  : divisor;
  assign q_fix   = qneg_q ? W'(0) - dsr_q : dsr_q;
  assign r_fix   = dneg_q ? W'(0) - prem_q[W-1:0] : prem_q[W-1:0];
  // Zero divisor: dsr still holds |dividend|, so undo the magnitude.
  assign dz_quot = dneg_q ? W'(1) : '1;
  assign dz_rem  = dneg_q ? W'(0) - dsr_q : dsr_q;

  always_comb begin
    dneg_d = dneg_q;
    qneg_d = qneg_q;
    if (state_q == IDLE && start) begin
      dneg_d = dividend[W-1];
      qneg_d = dividend[W-1] ^ divisor[W-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dneg_q <= 1'b0;
      qneg_q <= 1'b0;
    end else begin
      dneg_q <= dneg_d;
      qneg_q <= qneg_d;
    end
  end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_fix   = dsr_q;
  assign r_fix   = prem_q[W-1:0];
  assign dz_quot = '1;
  assign dz_rem  = dsr_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dsr_d   = dsr_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dsr_d   = dvd_mag;
          dvs_d   = dvs_mag;
          prem_d  = '0;
          cnt_d   = '0;
          dz_d    = 1'b0;
          state_d = (divisor == '0) ? FINISH : CALC;
        end
      end
      CALC: begin
        prem_d = step_rem;
        dsr_d  = {dsr_q[W-2:0], step_q};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) state_d = FINISH;
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (dvs_q == '0) begin
          quot_d = dz_quot;
          rem_d  = dz_rem;
          dz_d   = 1'b1;
        end else begin
          quot_d = q_fix;
          rem_d  = r_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dsr_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dsr_q   <= dsr_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign busy        = (state_q == CALC);
  assign done        = done_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
module tb_shift_sub_divider;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] dividend = '0, divisor = '0;
  logic        start = 1'b0;
  logic [15:0] quotient, remainder;
  logic        busy, done, div_by_zero;

  int   cyc = 0;
  int   nvec = 0;
  int   nmis = 0;
  int   done_seen = 0;
  logic prev_done = 1'b0;
  logic [15:0] last_q = '0, last_r = '0;
  exp_t sb[$];

  shift_sub_divider #(.TOP_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .dividend(dividend), .divisor(divisor),
    .start(start), .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Monitor: every done pops one expected result and checks value and timing.
  always @(negedge clk) begin
    if (rst) begin
      if (done) begin
        exp_t e;
        done_seen++;
        nvec++;
        if (prev_done) begin
          nmis++;
          $display("FAIL done_width: done high two cycles in a row at cyc %0d", cyc);
        end else if (sb.size() == 0) begin
          nmis++;
          $display("FAIL unexpected_done: got q=%h r=%h at cyc %0d, none expected", quotient, remainder, cyc);
        end else begin
          e = sb.pop_front();
          if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz || cyc != e.t) begin
            nmis++;
            $display("FAIL result: got q=%h r=%h dz=%b cyc=%0d, want q=%h r=%h dz=%b cyc=%0d",
                     quotient, remainder, div_by_zero, cyc, e.q, e.r, e.dz, e.t);
          end
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Issue start; returns once E0 has been sampled and the expectation queued.
  task automatic issue(input logic [15:0] a, b, eq, er, input logic edz, output int t0);
    exp_t e;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    e.q = eq; e.r = er; e.dz = edz; e.t = t0 + ((b == 16'h0) ? 1 : 17);
    sb.push_back(e);
    check("flag_clear_at_start", {15'b0, div_by_zero}, 16'h0);
    check("q_hold_at_start", quotient, last_q);
  endtask

  task automatic wait_done(input int seen0);
    for (int i = 0; i < 40 && done_seen == seen0; i++) @(negedge clk);
    #1;
    if (done_seen == seen0) begin
      nvec++; nmis++;
      $display("FAIL timeout: no done within 40 cycles");
      sb.delete();
    end
  endtask

  task automatic do_div(input logic [15:0] a, b, eq, er, input logic edz);
    int t0, s0;
    s0 = done_seen;
    issue(a, b, eq, er, edz, t0);
    wait_done(s0);
    last_q = eq; last_r = er;
    @(negedge clk);
  endtask

  function automatic void model(input logic [15:0] a, b, output logic [15:0] q, r, output logic dz);
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
    int sa, sd;
    sa = $signed(a); sd = $signed(b);
    dz = (b == 16'h0);
    if (dz) begin q = (sa < 0) ? 16'h0001 : 16'hFFFF; r = a; end
    else begin q = 16'(sa / sd); r = 16'(sa % sd); end
`else
    dz = (b == 16'h0);
    if (dz) begin q = 16'hFFFF; r = a; end
    else begin q = a / b; r = a % b; end
`endif
  endfunction

  initial begin
    int t0, s0;
    logic [15:0] a, b, eq, er;
    logic edz;

    #12;
    check("rst_quotient", quotient, 16'h0);
    check("rst_remainder", remainder, 16'h0);
    check("rst_flags", {13'b0, busy, done, div_by_zero}, 16'h0);
    @(negedge clk); rst = 1'b1;

`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
    do_div(16'h96E3, 16'h36F2, 16'hFFFF, 16'hCDD5, 1'b0);
`else
    do_div(16'h96E3, 16'h36F2, 16'h0002, 16'h28FF, 1'b0);
`endif
    do_div(16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1);
    do_div(16'h0005, 16'h0007, 16'h0000, 16'h0005, 1'b0);
    do_div(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0);
    do_div(16'h0000, 16'h0003, 16'h0000, 16'h0000, 1'b0);
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
    do_div(16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0);
    do_div(16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
    do_div(16'h8001, 16'h0000, 16'h0001, 16'h8001, 1'b1);
`else
    do_div(16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001, 1'b0);
    do_div(16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0);
    do_div(16'h8001, 16'h0000, 16'hFFFF, 16'h8001, 1'b1);
`endif

    // Second start in cycle 5 of a busy division is dropped.
    s0 = done_seen;
    issue(16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, t0);
    repeat (4) @(negedge clk);
    check("busy_mid_calc", {15'b0, busy}, 16'h0001);
    dividend = 16'h0001; divisor = 16'h0001; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("q_hold_mid_calc", quotient, last_q);
    check("r_hold_mid_calc", remainder, last_r);
    wait_done(s0);
    repeat (25) @(negedge clk);
    check("single_done", 16'(done_seen - s0), 16'h0001);
    last_q = 16'h000E; last_r = 16'h0002;

    // Reset in cycle 8 of CALC aborts with no done afterwards.
    s0 = done_seen;
    @(negedge clk); dividend = 16'hABCD; divisor = 16'h0013; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0; #1;
    check("abort_quotient", quotient, 16'h0);
    check("abort_remainder", remainder, 16'h0);
    check("abort_flags", {13'b0, busy, done, div_by_zero}, 16'h0);
    repeat (2) @(negedge clk); rst = 1'b1;
    repeat (25) @(negedge clk);
    check("no_done_after_rst", 16'(done_seen - s0), 16'h0000);
    last_q = '0; last_r = '0;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
    do_div(16'hABCD, 16'h0013, 16'hFB92, 16'hFFF7, 1'b0);
`else
    do_div(16'hABCD, 16'h0013, 16'h090A, 16'h000F, 1'b0);
`endif

    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'h0000;
        1, 2:    b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      model(a, b, eq, er, edz);
      do_div(a, b, eq, er, edz);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 16'(sb.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
